ysyx_23060332_wb_arbiter: RTL and testbench

Write-back arbiter and load scoreboard for the 32×32 register file. It shares the register file's single write port between the EXU (ALU/CSR results) and the LSU (load returns). It also tracks destinations of outstanding loads so the IDU can stall on RAW hazards. It sits between EXU/LSU and the register-file write port, and beside the IDU read-address path.

---
 rtl/ysyx_23060332_wb_arbiter_pkg.sv | 47 ++++
 rtl/ysyx_23060332_scoreboard.sv | 74 +++++++
 rtl/ysyx_23060332_wb_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_ysyx_23060332_wb_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_23060332_wb_arbiter_pkg.sv
// rtl/ysyx_23060332_wb_arbiter_pkg.sv - shared types, defaults and grant helper for the write-back arbiter
//
// Purpose:
//   Default widths, the starvation limit and the grant encoding used by
//   ysyx_23060332_wb_arbiter and ysyx_23060332_scoreboard.
//   The arbitration rule is a pure function here, so the priority policy
//   has a single definition.

package ysyx_23060332_wb_arbiter_pkg;

  // Default register-file geometry (32 x 32-bit) and starvation limit.
  localparam int ADDR_W_DEF     = 5;
  localparam int DATA_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 3;

  // Width of the starvation counter. It can hold STARVE_MAX values 1..7.
  localparam int STARVE_W = 3;

  // Which requester owns the write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_EXU  = 2'd1,
    GNT_LSU  = 2'd2
  } grant_e;

  // LSU wins by default, because load returns free scoreboard entries and
  // unblock the IDU. EXU wins outright once it has been starved long enough.
  // Nothing is granted while reset is held.
  function automatic grant_e arbitrate(
    input logic rst,
    input logic exu_valid,
    input logic lsu_valid,
    input logic exu_starved
  );
    grant_e g;
    g = GNT_NONE;
    if (!rst) begin
      if (exu_valid && (!lsu_valid || exu_starved)) begin
        g = GNT_EXU;
      end else if (lsu_valid) begin
        g = GNT_LSU;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/ysyx_23060332_scoreboard.sv
// rtl/ysyx_23060332_scoreboard.sv - outstanding-load scoreboard and RAW/WAW hazard lookup
//
// Purpose:
//   Tracks which registers have a load in flight. A pending bit is set when
//   the IDU issues a load, and cleared when the LSU write-back for that
//   register is accepted. Register x0 is never pending.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   issue_valid    IDU issues an instruction this cycle
//   issue_is_load  the issued instruction is a load
//   issue_rd       destination of the issued instruction
//   issue_hold     final (top-level) hazard: the issue does not take effect
//   clr_valid      LSU write-back accepted this cycle
//   clr_rd         destination of the accepted LSU write-back
//   rs1, rs2       IDU source addresses
//   sb_hazard      hazard caused by pending loads (RAW on rs1/rs2, WAW on rd)

module ysyx_23060332_scoreboard
  import ysyx_23060332_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_is_load,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              issue_hold,
  input  logic              clr_valid,
  input  logic [ADDR_W-1:0] clr_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              sb_hazard
);

  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  // The set is applied after the clear. When a load to rd issues in the same
  // cycle that an older return for rd is accepted, rd stays pending for the
  // new load.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (issue_valid && issue_is_load && !issue_hold && (issue_rd != '0)) begin
      set_vec[issue_rd] = 1'b1;
    end
    if (clr_valid) begin
      clr_vec[clr_rd] = 1'b1;
    end
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Bit 0 is always clear, so an x0 operand never stalls.
  // The issue_rd term blocks a second load to a register whose first load
  // is still outstanding (WAW).
  assign sb_hazard = pending_q[rs1] | pending_q[rs2] |
                     (issue_is_load & pending_q[issue_rd]);

endmodule

// File: rtl/ysyx_23060332_wb_arbiter.sv
// rtl/ysyx_23060332_wb_arbiter.sv - register-file write-port arbiter (EXU vs LSU) with load scoreboard
//
// Purpose:
//   Shares the single register-file write port between EXU results and LSU
//   load returns. LSU has default priority. EXU is forced through after
//   STARVE_MAX consecutive lost cycles. Accepted writes are registered and
//   presented to the register file one cycle later. A scoreboard
//   (ysyx_23060332_scoreboard) flags RAW/WAW hazards against outstanding
//   loads.
//
// Build option:
//   YSYX_23060332_WB_BYPASS_EN - forward the in-flight write to rs1/rs2
//   (fwdN_hit/fwdN_data). When this macro is undefined, the fwd outputs are 0
//   and hazard also stalls one cycle on a source that matches the in-flight
//   write.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   exu_valid/ready/rd/data       EXU write request and acceptance
//   lsu_valid/ready/rd/data       LSU load-return request and acceptance
//   issue_valid/is_load/rd        IDU issue information for the scoreboard
//   rs1, rs2                      IDU source addresses
//   hazard                        IDU must hold the current instruction
//   reg_wen, waddr, wdata         register-file write port (registered)
//   fwd1_hit/data, fwd2_hit/data  bypass of the in-flight write

module ysyx_23060332_wb_arbiter
  import ysyx_23060332_wb_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exu_valid,
  output logic              exu_ready,
  input  logic [ADDR_W-1:0] exu_rd,
  input  logic [DATA_W-1:0] exu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              issue_valid,
  input  logic              issue_is_load,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              hazard,
  output logic              reg_wen,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd1_data,
  output logic [DATA_W-1:0] fwd2_data
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  grant_e              grant;
  logic [STARVE_W-1:0] starve_q;
  logic [STARVE_W-1:0] starve_d;

  logic                reg_wen_q;
  logic                reg_wen_d;
  logic [ADDR_W-1:0]   waddr_q;
  logic [ADDR_W-1:0]   waddr_d;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   wdata_d;

  logic                sb_hazard;
  logic                inflight_hazard;

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  assign grant     = arbitrate(rst, exu_valid, lsu_valid, starve_q == STARVE_LIM);
  assign exu_ready = (grant == GNT_EXU);
  assign lsu_ready = (grant == GNT_LSU);

  // The counter tracks consecutive cycles in which EXU waited. It resets as
  // soon as EXU is served or withdraws. It never passes STARVE_LIM, because
  // reaching the limit hands the port to EXU.
  always_comb begin
    starve_d = '0;
    if (exu_valid && (grant != GNT_EXU) && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + 1'b1;
    end else if (exu_valid && (grant != GNT_EXU)) begin
      starve_d = starve_q;
    end
  end

  // ---------------------------------------------------------------------
  // Write-port register
  // ---------------------------------------------------------------------
  // A write to x0 is accepted so the requester can retire it, but it never
  // raises reg_wen. Address and data hold their last value while idle.
  always_comb begin
    reg_wen_d = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    unique case (grant)
      GNT_EXU: begin
        reg_wen_d = (exu_rd != '0);
        waddr_d   = exu_rd;
        wdata_d   = exu_data;
      end
      GNT_LSU: begin
        reg_wen_d = (lsu_rd != '0);
        waddr_d   = lsu_rd;
        wdata_d   = lsu_data;
      end
      default: begin
        reg_wen_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      reg_wen_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      starve_q  <= starve_d;
      reg_wen_q <= reg_wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  assign reg_wen = reg_wen_q;
  assign waddr   = waddr_q;
  assign wdata   = wdata_q;

  // ---------------------------------------------------------------------
  // Load scoreboard
  // ---------------------------------------------------------------------
  // The scoreboard uses the complete hazard to decide whether an issue takes
  // effect. A held load must not mark its destination pending.
  ysyx_23060332_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .issue_valid  (issue_valid),
    .issue_is_load(issue_is_load),
    .issue_rd     (issue_rd),
    .issue_hold   (hazard),
    .clr_valid    (lsu_ready),
    .clr_rd       (lsu_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .sb_hazard    (sb_hazard)
  );

  // ---------------------------------------------------------------------
  // In-flight write: bypass or one-cycle stall
  // ---------------------------------------------------------------------
`ifdef YSYX_23060332_WB_BYPASS_EN
  assign fwd1_hit        = reg_wen_q && (waddr_q == rs1) && (rs1 != '0);
  assign fwd2_hit        = reg_wen_q && (waddr_q == rs2) && (rs2 != '0);
  assign fwd1_data       = wdata_q;
  assign fwd2_data       = wdata_q;
  assign inflight_hazard = 1'b0;
`else
  // The register file commits this write only at the next edge. A read in
  // this cycle would return stale data, so the IDU waits one cycle.
  assign fwd1_hit        = 1'b0;
  assign fwd2_hit        = 1'b0;
  assign fwd1_data       = '0;
  assign fwd2_data       = '0;
  assign inflight_hazard = reg_wen_q && (waddr_q != '0) &&
                           ((waddr_q == rs1) || (waddr_q == rs2));
`endif

  assign hazard = sb_hazard | inflight_hazard;

endmodule

// File: tb/tb_ysyx_23060332_wb_arbiter.sv
// tb/tb_ysyx_23060332_wb_arbiter.sv - table-driven self-checking bench for the write-back arbiter

module tb_ysyx_23060332_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd, issue_rd, rs1, rs2, waddr;
  logic [31:0] exu_data, lsu_data, wdata, fwd1_data, fwd2_data;
  logic        issue_valid, issue_is_load, hazard, reg_wen, fwd1_hit, fwd2_hit;

  int errors = 0;
  int checks = 0;

`ifdef YSYX_23060332_WB_BYPASS_EN
  localparam int B = 1;
`else
  localparam int B = 0;
`endif
  localparam int NB = 1 - B;
  localparam logic [31:0] FWD_AA = (B == 1) ? 32'hAA : 32'h0;

  always #5 clk = ~clk;

  ysyx_23060332_wb_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .exu_valid    (exu_valid),
    .exu_ready    (exu_ready),
    .exu_rd       (exu_rd),
    .exu_data     (exu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_rd       (lsu_rd),
    .lsu_data     (lsu_data),
    .issue_valid  (issue_valid),
    .issue_is_load(issue_is_load),
    .issue_rd     (issue_rd),
    .rs1          (rs1),
    .rs2          (rs2),
    .hazard       (hazard),
    .reg_wen      (reg_wen),
    .waddr        (waddr),
    .wdata        (wdata),
    .fwd1_hit     (fwd1_hit),
    .fwd2_hit     (fwd2_hit),
    .fwd1_data    (fwd1_data),
    .fwd2_data    (fwd2_data)
  );

  typedef struct {
    logic        ev;  logic [4:0] erd; logic [31:0] ed;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        iv;  logic       il;  logic [4:0]  ird;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        xer; logic       xlr; logic        xhz;
    logic        xwen; logic [4:0] xwa; logic [31:0] xwd; logic xf1;
  } vec_t;

  vec_t tbl[$];

  task automatic add_v(input int ev, input int erd, input int ed,
                       input int lv, input int lrd, input int ld,
                       input int iv, input int il, input int ird,
                       input int r1, input int r2,
                       input int xer, input int xlr, input int xhz,
                       input int xwen, input int xwa, input int xwd, input int xf1);
    vec_t v;
    v.ev = 1'(ev);   v.erd = 5'(erd); v.ed = 32'(ed);
    v.lv = 1'(lv);   v.lrd = 5'(lrd); v.ld = 32'(ld);
    v.iv = 1'(iv);   v.il = 1'(il);   v.ird = 5'(ird);
    v.r1 = 5'(r1);   v.r2 = 5'(r2);
    v.xer = 1'(xer); v.xlr = 1'(xlr); v.xhz = 1'(xhz);
    v.xwen = 1'(xwen); v.xwa = 5'(xwa); v.xwd = 32'(xwd); v.xf1 = 1'(xf1);
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    exu_valid = 1'b0; exu_rd = '0; exu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_is_load = 1'b0; issue_rd = '0;
    rs1 = '0; rs2 = '0;
  endtask

  initial begin
    //    ev erd ed       lv lrd ld     iv il ird r1 r2  er lr hz  wen wa wd       f1
    // single EXU write
    add_v(1, 5, 'h1234,  0, 0, 0,      0, 0, 0,  0, 0,  1, 0, 0,  0, 0, 0,       0);
    add_v(0, 0, 0,       0, 0, 0,      0, 0, 0,  0, 0,  0, 0, 0,  1, 5, 'h1234,  0);
    add_v(0, 0, 0,       0, 0, 0,      0, 0, 0,  0, 0,  0, 0, 0,  0, 0, 0,       0);
    // collision and starvation (STARVE_MAX = 3)
    add_v(1, 1, 'h11,    1, 2, 'h22,   0, 0, 0,  0, 0,  0, 1, 0,  0, 0, 0,       0);
    add_v(1, 1, 'h11,    1, 2, 'h22,   0, 0, 0,  0, 0,  0, 1, 0,  1, 2, 'h22,    0);
    add_v(1, 1, 'h11,    1, 2, 'h22,   0, 0, 0,  0, 0,  0, 1, 0,  1, 2, 'h22,    0);
    add_v(1, 1, 'h11,    1, 2, 'h22,   0, 0, 0,  0, 0,  1, 0, 0,  1, 2, 'h22,    0);
    add_v(1, 1, 'h11,    1, 2, 'h22,   0, 0, 0,  0, 0,  0, 1, 0,  1, 1, 'h11,    0);
    add_v(0, 0, 0,       0, 0, 0,      0, 0, 0,  0, 0,  0, 0, 0,  1, 2, 'h22,    0);
    add_v(0, 0, 0,       0, 0, 0,      0, 0, 0,  0, 0,  0, 0, 0,  0, 0, 0,       0);
    // load scoreboard: issue rd7, RAW on rs1, return clears
    add_v(0, 0, 0,       0, 0, 0,      1, 1, 7,  0, 0,  0, 0, 0,  0, 0, 0,       0);
    add_v(0, 0, 0,       0, 0, 0,      0, 0, 0,  7, 0,  0, 0, 1,  0, 0, 0,       0);
    add_v(0, 0, 0,       1, 7, 'h77,   0, 0, 0,  7, 0,  0, 1, 1,  0, 0, 0,       0);
    add_v(0, 0, 0,       0, 0, 0,      0, 0, 0,  7, 0,  0, 0, NB, 1, 7, 'h77,    B);
    add_v(0, 0, 0,       0, 0, 0,      0, 0, 0,  7, 0,  0, 0, 0,  0, 0, 0,       0);
    // same-cycle set and clear on rd9: set wins
    add_v(0, 0, 0,       1, 9, 'h99,   1, 1, 9,  0, 0,  0, 1, 0,  0, 0, 0,       0);
    add_v(0, 0, 0,       0, 0, 0,      0, 0, 0,  9, 0,  0, 0, 1,  1, 9, 'h99,    B);
    add_v(0, 0, 0,       0, 0, 0,      0, 0, 0,  9, 0,  0, 0, 1,  0, 0, 0,       0);
    // WAW: second load to rd9 held
    add_v(0, 0, 0,       0, 0, 0,      1, 1, 9,  0, 0,  0, 0, 1,  0, 0, 0,       0);
    add_v(0, 0, 0,       1, 9, 'h5,    0, 0, 0,  0, 0,  0, 1, 0,  0, 0, 0,       0);
    add_v(0, 0, 0,       0, 0, 0,      0, 0, 0,  9, 0,  0, 0, NB, 1, 9, 'h5,     B);
    add_v(0, 0, 0,       0, 0, 0,      0, 0, 0,  9, 0,  0, 0, 0,  0, 0, 0,       0);
    // x0 handling
    add_v(1, 0, 'hDEAD,  0, 0, 0,      0, 0, 0,  0, 0,  1, 0, 0,  0, 0, 0,       0);
    add_v(0, 0, 0,       0, 0, 0,      0, 0, 0,  0, 0,  0, 0, 0,  0, 0, 0,       0);
    add_v(0, 0, 0,       0, 0, 0,      1, 1, 0,  0, 0,  0, 0, 0,  0, 0, 0,       0);
    add_v(0, 0, 0,       0, 0, 0,      0, 1, 0,  0, 0,  0, 0, 0,  0, 0, 0,       0);

    // reset: requesters valid but not accepted
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    exu_valid = 1'b1; exu_rd = 5'd4; lsu_valid = 1'b1; lsu_rd = 5'd6;
    #4;
    chk("rst exu_ready", 32'(exu_ready), 0);
    chk("rst lsu_ready", 32'(lsu_ready), 0);
    @(negedge clk);
    #4;
    chk("rst reg_wen", 32'(reg_wen), 0);
    chk("rst waddr", 32'(waddr), 0);
    chk("rst wdata", wdata, 0);
    chk("rst fwd1_hit", 32'(fwd1_hit), 0);
    chk("rst fwd2_data", fwd2_data, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      exu_valid = tbl[i].ev; exu_rd = tbl[i].erd; exu_data = tbl[i].ed;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
      issue_valid = tbl[i].iv; issue_is_load = tbl[i].il; issue_rd = tbl[i].ird;
      rs1 = tbl[i].r1; rs2 = tbl[i].r2;
      #4;
      chk($sformatf("v%0d exu_ready", i), 32'(exu_ready), 32'(tbl[i].xer));
      chk($sformatf("v%0d lsu_ready", i), 32'(lsu_ready), 32'(tbl[i].xlr));
      chk($sformatf("v%0d hazard", i), 32'(hazard), 32'(tbl[i].xhz));
      chk($sformatf("v%0d reg_wen", i), 32'(reg_wen), 32'(tbl[i].xwen));
      chk($sformatf("v%0d fwd1_hit", i), 32'(fwd1_hit), 32'(tbl[i].xf1));
      if (tbl[i].xwen) begin
        chk($sformatf("v%0d waddr", i), 32'(waddr), 32'(tbl[i].xwa));
        chk($sformatf("v%0d wdata", i), wdata, tbl[i].xwd);
      end
    end

    // in-flight write read on rs2: bypass or one-cycle stall
    @(negedge clk);
    idle_inputs();
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'hAA;
    #4;
    chk("byp exu_ready", 32'(exu_ready), 1);
    @(negedge clk);
    idle_inputs();
    rs2 = 5'd3;
    #4;
    chk("byp reg_wen", 32'(reg_wen), 1);
    chk("byp fwd2_hit", 32'(fwd2_hit), 32'(B));
    chk("byp fwd2_data", fwd2_data, FWD_AA);
    chk("byp hazard", 32'(hazard), 32'(NB));
    @(negedge clk);
    #4;
    chk("byp hazard after", 32'(hazard), 0);
    chk("byp fwd2_hit after", 32'(fwd2_hit), 0);

    // reset during the reg_wen cycle discards the write and the pending load
    @(negedge clk);
    idle_inputs();
    issue_valid = 1'b1; issue_is_load = 1'b1; issue_rd = 5'd12;
    exu_valid = 1'b1; exu_rd = 5'd4; exu_data = 32'h44;
    #4;
    chk("rmid exu_ready", 32'(exu_ready), 1);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    exu_valid = 1'b1; exu_rd = 5'd4; exu_data = 32'h44;
    rs1 = 5'd12;
    #4;
    chk("rmid reg_wen before", 32'(reg_wen), 1);
    chk("rmid hazard before", 32'(hazard), 1);
    chk("rmid exu_ready in rst", 32'(exu_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
    rs1 = 5'd12;
    #4;
    chk("rmid reg_wen after", 32'(reg_wen), 0);
    chk("rmid waddr after", 32'(waddr), 0);
    chk("rmid wdata after", wdata, 0);
    chk("rmid hazard after", 32'(hazard), 0);
    @(negedge clk);
    #4;
    chk("rmid reg_wen later", 32'(reg_wen), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
